// File: rtl/jpeg_pkg.sv
// Shared constants and types for the JPEG DCT front-end blocks.
// Sample width, block geometry, replay-order encodings and sequencer states.
package jpeg_pkg;

  localparam int DW    = 8;
  localparam int N     = 8;
  localparam int LOG2N = $clog2(N);
  localparam int BLK   = N * N;

  localparam logic ORD_ROW = 1'b0;
  localparam logic ORD_COL = 1'b1;

  typedef enum logic {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } seq_state_t;

endpackage

// File: rtl/dct_blk_seq_if.sv
// Pixel-in / DCT-lane-out handshake bundle for the block sequencer.
// slave = sequencer view, master = producer/consumer (environment) view.
interface dct_blk_seq_if import jpeg_pkg::*; ();

  logic [DW-1:0] in_data;
  logic          in_valid;
  logic          in_ready;
  logic          in_order;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic          out_row_start;
  logic          out_row_last;
  logic          out_blk_last;

  modport slave (
    input  in_data, in_valid, in_order, out_ready,
    output in_ready, out_data, out_valid, out_row_start, out_row_last, out_blk_last
  );

  modport master (
    output in_data, in_valid, in_order, out_ready,
    input  in_ready, out_data, out_valid, out_row_start, out_row_last, out_blk_last
  );

endinterface

// File: rtl/dct_blk_seq_bank.sv
// One N*N sample buffer of the ping-pong pair: synchronous write port,
// combinational read port, full flag and the replay order latched with
// the first sample of the block.
module dct_blk_bank import jpeg_pkg::*; (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 we,
  input  logic [2*LOG2N-1:0]   waddr,
  input  logic [DW-1:0]        wdata,
  input  logic                 ord_we,
  input  logic                 ord_in,
  input  logic                 set_full,
  input  logic                 clr_full,
  input  logic [2*LOG2N-1:0]   raddr,
  output logic [DW-1:0]        rdata,
  output logic                 full,
  output logic                 ord
);

  logic [DW-1:0] mem [BLK];

  // Sample storage; contents only matter while the bank is full, so no reset.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

  // Full flag and order bit. Set and clear never target the same bank in
  // one cycle (writes need !full, drains need full); set wins regardless.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      full <= 1'b0;
      ord  <= ORD_ROW;
    end else begin
      if (set_full)      full <= 1'b1;
      else if (clr_full) full <= 1'b0;
      if (ord_we)        ord  <= ord_in;
    end
  end

endmodule

// File: rtl/dct_blk_seq.sv
// Block sequencer ahead of the DCT lane. Raster pixels fill one bank while
// the other bank replays its block row-major or column-major with row and
// block framing strobes, so consecutive blocks reach the lane back-to-back.
// Optional: DCT_LEVEL_SHIFT_EN inverts the output MSB (unsigned -> signed
// level shift); stored samples are unaffected.
module dct_blk_seq import jpeg_pkg::*; (
  input  logic           clk,
  input  logic           rst,
  dct_blk_seq_if.slave   bus,
  output logic           busy
);

  localparam int AW = 2 * LOG2N;

  seq_state_t             state, state_nx;
  logic                   wbank, rbank;
  logic [AW-1:0]          wcnt, rcnt;
  logic [AW-1:0]          raddr;
  logic [1:0]             full, ord;
  logic [1:0][DW-1:0]     rdata;
  logic [DW-1:0]          sample;
  logic                   wr_fire, wr_last, rd_fire, rd_last;

  // in_ready is forced low during reset so every output reads 0 there.
  assign bus.in_ready = rst && !full[wbank];
  assign wr_fire      = bus.in_valid && bus.in_ready;
  assign wr_last      = wr_fire && (wcnt == '1);
  assign rd_fire      = bus.out_valid && bus.out_ready;
  assign rd_last      = rd_fire && (rcnt == '1);

  // Column-major replay swaps the row and column halves of the index.
  assign raddr = (ord[rbank] == ORD_COL) ? {rcnt[LOG2N-1:0], rcnt[AW-1:LOG2N]} : rcnt;

  for (genvar b = 0; b < 2; b++) begin : g_bank
    dct_blk_bank u_bank (
      .clk      (clk),
      .rst      (rst),
      .we       (wr_fire && (wbank == 1'(b))),
      .waddr    (wcnt),
      .wdata    (bus.in_data),
      .ord_we   (wr_fire && (wbank == 1'(b)) && (wcnt == '0)),
      .ord_in   (bus.in_order),
      .set_full (wr_last && (wbank == 1'(b))),
      .clr_full (rd_last && (rbank == 1'(b))),
      .raddr    (raddr),
      .rdata    (rdata[b]),
      .full     (full[b]),
      .ord      (ord[b])
    );
  end

  // Write and read counters; both wrap to 0 naturally at BLK-1, which also
  // restarts rcnt at 0 for a back-to-back block.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wcnt  <= '0;
      wbank <= 1'b0;
      rcnt  <= '0;
      rbank <= 1'b0;
    end else begin
      if (wr_fire) wcnt  <= wcnt + 1'b1;
      if (wr_last) wbank <= ~wbank;
      if (rd_fire) rcnt  <= rcnt + 1'b1;
      if (rd_last) rbank <= ~rbank;
    end
  end

  // Read FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  // Next state: leave DRAIN only if the other bank is not yet full.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (full[rbank]) state_nx = DRAIN;
      DRAIN:   if (rd_last && !full[~rbank]) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Output data path with optional level shift, zeroed when not valid.
  always_comb begin
    sample = rdata[rbank];
`ifdef DCT_LEVEL_SHIFT_EN
    sample[DW-1] = ~sample[DW-1];
`endif
  end

  assign bus.out_valid     = (state == DRAIN);
  assign bus.out_data      = bus.out_valid ? sample : '0;
  assign bus.out_row_start = bus.out_valid && (rcnt[LOG2N-1:0] == '0);
  assign bus.out_row_last  = bus.out_valid && (rcnt[LOG2N-1:0] == '1);
  assign bus.out_blk_last  = bus.out_valid && (rcnt == '1);

  assign busy = full[0] | full[1] | (wcnt != '0);

endmodule

// File: tb/tb_dct_blk_seq.sv
// Bench for dct_blk_seq: directed blocks checked through a vector table,
// randomized streaming with backpressure against a block-level model,
// and a reset in the middle of traffic.
module tb_dct_blk_seq;
  import jpeg_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic busy;

  dct_blk_seq_if bus ();

  dct_blk_seq dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus),
    .busy (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] d;
    bit rs, rl, bl;
  } smp_t;

  typedef struct {
    int         b;
    int         pos;
    logic [7:0] d;
    bit rs, rl, bl;
  } vec_t;

  int n_chk = 0;
  int n_pass = 0;

  smp_t expq[$];
  smp_t cap[$];
  int   cap_cyc[$];
  vec_t tbl[$];

  logic [7:0] blkdat[BLK];
  logic [7:0] wbuf[BLK];
  bit   word_ord;
  int   wpos = 0, nfull = 0, cyc = 0;
  bit   prev_stall = 0;
  smp_t prev_s;
  bit   capture = 0;
  int   last_in_edge = -1, first_valid = -1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic logic [7:0] ls(input logic [7:0] x);
`ifdef DCT_LEVEL_SHIFT_EN
    return x ^ 8'h80;
`else
    return x;
`endif
  endfunction

  // Expected replay of a completed block, straight from the order rules.
  function automatic void push_block();
    smp_t e;
    int   idx;
    for (int i = 0; i < BLK; i++) begin
      idx  = word_ord ? (i % N) * N + (i / N) : i;
      e.d  = ls(wbuf[idx]);
      e.rs = (i % N == 0);
      e.rl = (i % N == N - 1);
      e.bl = (i == BLK - 1);
      expq.push_back(e);
    end
  endfunction

  // One clock: sample outputs at the falling edge, check them, drive new
  // inputs, then account for what the next rising edge will transfer.
  task automatic cycle(input bit iv, input logic [7:0] d, input bit ord,
                       input bit ordy, output bit acc);
    smp_t s, e;
    bit   ov, ir;
    @(negedge clk);
    cyc++;
    ov   = bus.out_valid;
    ir   = bus.in_ready;
    s.d  = bus.out_data;
    s.rs = bus.out_row_start;
    s.rl = bus.out_row_last;
    s.bl = bus.out_blk_last;
    check("in_ready", ir, nfull < 2);
    check("busy", busy, (nfull > 0) || (wpos != 0));
    if (!ov) check("idle_outs", {s.d, s.rs, s.rl, s.bl}, 0);
    if (prev_stall) begin
      check("stall_data", s.d, prev_s.d);
      check("stall_strobes", {s.rs, s.rl, s.bl}, {prev_s.rs, prev_s.rl, prev_s.bl});
    end
    if (ov && first_valid < 0) first_valid = cyc;
    bus.in_valid  = iv;
    bus.in_data   = d;
    bus.in_order  = ord;
    bus.out_ready = ordy;
    acc = iv && ir;
    if (ov && ordy) begin
      check("out_expected", expq.size() != 0, 1);
      if (expq.size() != 0) begin
        e = expq.pop_front();
        check("out_data", s.d, e.d);
        check("out_strobes", {s.rs, s.rl, s.bl}, {e.rs, e.rl, e.bl});
        if (e.bl) nfull--;
      end
      if (capture) begin
        cap.push_back(s);
        cap_cyc.push_back(cyc);
      end
    end
    if (acc) begin
      wbuf[wpos] = d;
      if (wpos == 0) word_ord = ord;
      if (wpos == BLK - 1) begin
        push_block();
        nfull++;
        wpos = 0;
        last_in_edge = cyc + 1;
      end else wpos++;
    end
    prev_stall = ov && !ordy;
    prev_s     = s;
  endtask

  task automatic send_block(input bit ord, input int vpct, input int rpct);
    int got = 0, guard = 0;
    bit acc;
    while (got < BLK && guard < 2000) begin
      cycle(($urandom % 100) < vpct, blkdat[got], ord, ($urandom % 100) < rpct, acc);
      if (acc) got++;
      guard++;
    end
    check("send_done", got, BLK);
  endtask

  task automatic drain(input int rpct);
    int guard = 0;
    bit acc;
    while (expq.size() > 0 && guard < 3000) begin
      cycle(1'b0, 8'h00, 1'b0, ($urandom % 100) < rpct, acc);
      guard++;
    end
    check("drain_done", expq.size(), 0);
    repeat (4) cycle(1'b0, 8'h00, 1'b0, 1'b1, acc);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat0;
    int base;
    bit acc;
    int got;

    bus.in_valid = 0; bus.in_data = '0; bus.in_order = 0; bus.out_ready = 0;

    // Reset state: every output low.
    repeat (3) @(negedge clk);
    check("reset_outs", {bus.out_valid, bus.out_data, bus.out_row_start, bus.out_row_last,
                         bus.out_blk_last, bus.in_ready, busy}, 0);
    rst = 1'b1;

    // Hand-computed vectors for the three directed blocks.
    tbl.push_back('{0, 0,  ls(8'd0),  1, 0, 0});
    tbl.push_back('{0, 7,  ls(8'd7),  0, 1, 0});
    tbl.push_back('{0, 8,  ls(8'd8),  1, 0, 0});
    tbl.push_back('{0, 31, ls(8'd31), 0, 1, 0});
    tbl.push_back('{0, 56, ls(8'd56), 1, 0, 0});
    tbl.push_back('{0, 63, ls(8'd63), 0, 1, 1});
    tbl.push_back('{1, 1,  ls(8'd8),  0, 0, 0});
    tbl.push_back('{1, 7,  ls(8'd56), 0, 1, 0});
    tbl.push_back('{1, 8,  ls(8'd1),  1, 0, 0});
    tbl.push_back('{1, 15, ls(8'd57), 0, 1, 0});
    tbl.push_back('{1, 56, ls(8'd7),  1, 0, 0});
    tbl.push_back('{1, 63, ls(8'd63), 0, 1, 1});
`ifdef DCT_LEVEL_SHIFT_EN
    tbl.push_back('{2, 0, 8'h80, 1, 0, 0});
    tbl.push_back('{2, 1, 8'h00, 0, 0, 0});
    tbl.push_back('{2, 2, 8'h7F, 0, 0, 0});
`else
    tbl.push_back('{2, 0, 8'h00, 1, 0, 0});
    tbl.push_back('{2, 1, 8'h80, 0, 0, 0});
    tbl.push_back('{2, 2, 8'hFF, 0, 0, 0});
`endif

    // Directed: row block, column block, level-shift probe block, streamed
    // back-to-back with the lane always ready.
    capture = 1;
    lat0 = -1;
    for (int b = 0; b < 3; b++) begin
      for (int i = 0; i < BLK; i++) blkdat[i] = 8'(i);
      if (b == 2) begin
        blkdat[1] = 8'h80;
        blkdat[2] = 8'hFF;
      end
      send_block(b == 1, 100, 100);
      if (b == 0) lat0 = last_in_edge;
    end
    drain(100);
    check("latency", first_valid, lat0 + 1);
    check("cap_count", cap.size(), 3 * BLK);
    if (cap.size() == 3 * BLK) begin
      check("no_gap", cap_cyc[2*BLK-1] - cap_cyc[0], 2 * BLK - 1);
      foreach (tbl[k]) begin
        base = tbl[k].b * BLK + tbl[k].pos;
        check($sformatf("vec%0d_data", k), cap[base].d, tbl[k].d);
        check($sformatf("vec%0d_strb", k), {cap[base].rs, cap[base].rl, cap[base].bl},
              {tbl[k].rs, tbl[k].rl, tbl[k].bl});
      end
    end

    // Randomized data, order and flow control on both sides.
    capture = 0;
    for (int b = 0; b < 6; b++) begin
      for (int i = 0; i < BLK; i++) blkdat[i] = 8'($urandom);
      send_block(1'($urandom), 70, 50);
    end
    drain(50);

    // Reset mid-operation: block A draining, 30 samples of block B written.
    for (int i = 0; i < BLK; i++) blkdat[i] = 8'(i + 200);
    send_block(0, 100, 100);
    got = 0;
    while (got < 30) begin
      cycle(1'b1, 8'(got), 1'b0, 1'b1, acc);
      if (acc) got++;
    end
    #2 rst = 1'b0;
    bus.in_valid = 0;
    #1;
    check("midrst_outs", {bus.out_valid, bus.out_data, bus.out_row_start, bus.out_row_last,
                          bus.out_blk_last, bus.in_ready, busy}, 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    expq.delete();
    nfull = 0;
    wpos = 0;
    prev_stall = 0;

    capture = 1;
    cap.delete();
    cap_cyc.delete();
    for (int i = 0; i < BLK; i++) blkdat[i] = 8'(i + 100);
    send_block(0, 100, 100);
    drain(100);
    check("post_rst_count", cap.size(), BLK);
    if (cap.size() == BLK) begin
      check("post_rst_first", cap[0].d, ls(8'd100));
      check("post_rst_last", cap[BLK-1].d, ls(8'd163));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/dct_blk_seq.md
Name: dct_blk_seq

Overview:
- Block sequencer in front of the DCT stage datapath (dct12 and its siblings); both pipeline passes (row and column) share it.
- Collects raster-order pixels into N×N blocks in a ping-pong buffer.
- Replays each full block to the DCT lane in row-major or column-major (transposed) order, with row/block framing strobes.
- Filling one bank overlaps draining the other, so the DCT lane sees back-to-back blocks.

Parameters:
- DW, 8, sample width in bits.
- N, 8, block dimension; power of two, 2..16; block = N*N samples.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- in_data  in  DW  input sample, raster order within the block.
- in_valid  in  1  input sample valid.
- in_ready  out  1  block can accept a sample.
- in_order  in  1  sampled with the first sample of a block: 0 = row-major replay, 1 = column-major replay.
- out_data  out  DW  sample to the DCT lane.
- out_valid  out  1  out_data valid.
- out_ready  in  1  DCT lane accepts.
- out_row_start  out  1  first sample of a row/column group (qualified by out_valid).
- out_row_last  out  1  last sample of a group.
- out_blk_last  out  1  last sample of the block.
- busy  out  1  any bank full or partially written.

Behaviour:
- Reset (rst=0, async):
  - All outputs 0.
  - Bank full flags cleared; write and read bank selects = 0; counters = 0; FSM = IDLE.
  - A partially written or partially drained block is discarded.
- Storage: two banks of N*N × DW registers. Each bank has a full flag and a latched order bit.
- Write side:
  - in_ready = !full[wbank].
  - On in_valid && in_ready: mem[wbank][wcnt] <= in_data.
  - If wcnt==0, order[wbank] <= in_order.
  - If wcnt==N*N-1: full[wbank] <= 1, wbank toggles, wcnt <= 0. Otherwise wcnt++.
- Read FSM, states IDLE and DRAIN:
  - IDLE: if full[rbank], go to DRAIN with rcnt=0.
  - DRAIN: out_valid=1.
    - Address = rcnt for row-major order.
    - Address = {rcnt[low log2N], rcnt[high log2N]} (index swap) for column-major order.
    - out_data is read combinationally from the addressed entry.
    - On out_valid && out_ready: rcnt++.
    - At rcnt==N*N-1 with handshake: full[rbank] <= 0, rbank toggles.
      - If the other bank is already full (flag registered as of this cycle), stay in DRAIN with rcnt=0 (no bubble).
      - Otherwise go to IDLE.
- Strobes, all qualified by out_valid:
  - out_row_start = (rcnt mod N == 0).
  - out_row_last = (rcnt mod N == N-1).
  - out_blk_last = (rcnt == N*N-1).
- Latency: last input sample accepted at edge k → full flag set at k → out_valid=1 in the cycle after edge k+1 (IDLE→DRAIN). Minimum fill-to-first-output is 1 cycle.
- Backpressure: out_data and all strobes hold stable while out_valid && !out_ready.
- Both banks full: in_ready=0 until the draining bank completes. in_ready rises the cycle after the freeing handshake.
- Simultaneous fill-complete and drain-complete on different banks in the same cycle: both take effect. No sample lost or duplicated.
- busy = full[0] | full[1] | (wcnt != 0).

Optional Feature:
- Macro: DCT_LEVEL_SHIFT_EN.
- Defined: out_data = stored sample with MSB inverted, i.e. unsigned pixel − 2^(DW−1) in two's complement (JPEG level shift). Applies only at the output; storage is unchanged.
- Undefined: out_data = stored sample unmodified.

Decomposition:
- Shared package jpeg_pkg holds:
  - DW, N, and derived constants LOG2N and BLK = N*N.
  - Order encodings ORD_ROW=0, ORD_COL=1.
  - FSM state typedef (IDLE, DRAIN).
- One sub-module, dct_blk_bank: a single N*N buffer with write port, combinational read port, full flag and order bit; instantiated twice.
- Sequencer FSM, counters and strobe logic stay in the top.

Test Plan:
- Row-major single block: stream 0..63 with in_order=0, out_ready=1 → out_data 0..63 in order; out_row_start at 0,8,…,56; out_row_last at 7,15,…,63; out_blk_last only at 63; out_valid goes high the cycle after edge k+1.
- Column-major replay: stream 0..63 with in_order=1 → output 0,8,16,…,56,1,9,…,63; row strobes every 8 samples.
- Back-to-back blocks: three blocks streamed continuously with out_ready=1 → no gap in out_valid between blocks 1 and 2; in_ready drops only while both banks are full; all 192 samples are correct.
- Backpressure: toggle out_ready randomly at 50% → out_data and strobes stable while stalled; sequence identical to the no-stall case.
- Reset mid-operation: assert rst after 30 samples of block 2 while block 1 is draining → outputs 0 immediately; after release, a fresh block 100..163 drains as 100..163 with no stale data.
- DCT_LEVEL_SHIFT_EN: input 0x00, 0x80, 0xFF → outputs 0x80, 0x00, 0x7F. Without the macro: 0x00, 0x80, 0xFF.
